// File: rtl/seq_divider_7by4.sv
// seq_divider_7by4: restoring divider, 7-bit dividend by 4-bit divisor, one shift-subtract step per clock
module seq_divider_7by4 #(
  parameter int DW = 7,
  parameter int VW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_by_zero
);
  localparam int CW = $clog2(DW);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_n;
  logic [VW:0] r, r_sh, r_sub;
  logic [DW-1:0] d, d_sh;
  logic [VW-1:0] v;
  logic [CW-1:0] cnt;
  logic ge, accept, zero, last;
  always_comb begin
    r_sh = {r[VW-1:0], d[DW-1]};
    ge = r_sh >= {1'b0, v};
    r_sub = ge ? r_sh - {1'b0, v} : r_sh;
    d_sh = {d[DW-2:0], ge};
    accept = start && state != CALC;
    zero = divisor == '0;
    last = cnt == CW'(DW - 1);
    state_n = accept ? (zero ? DONE : CALC) : (state == CALC) ? (last ? DONE : CALC) : IDLE;
    busy = state == CALC;
    done = state == DONE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      r <= '0;
      d <= '0;
      v <= '0;
      cnt <= '0;
      quotient <= '0;
      remainder <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state <= state_n;
      if (accept && !zero) begin
        d <= dividend;
        v <= divisor;
        r <= '0;
        cnt <= '0;
      end else if (accept) begin
        quotient <= {DW{1'b1}};
        remainder <= '0;
        div_by_zero <= 1'b1;
      end else if (state == CALC) begin
        r <= r_sub;
        d <= d_sh;
        cnt <= cnt + 1'b1;
        if (last) begin
          quotient <= d_sh;
          remainder <= r_sub[VW-1:0];
          div_by_zero <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_seq_divider_7by4.sv
// tb_seq_divider_7by4: scoreboard bench for the sequential 7-by-4 divider
module tb_seq_divider_7by4;
  logic clk = 1'b0;
  logic rst, start, busy, done, div_by_zero;
  logic [6:0] dividend, quotient;
  logic [3:0] divisor, remainder;
  typedef struct {logic [6:0] q; logic [3:0] r; logic z;} exp_t;
  exp_t sb[$];
  exp_t got;
  int errors = 0, checks = 0;
  int cyc = 0, busy_total = 0, e0 = 0, b0 = 0;
  bit ok;
  seq_divider_7by4 dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (busy) busy_total <= busy_total + 1;
  always @(negedge clk) begin
    if (done) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done q=%0d r=%0d z=%0b with no pending request", quotient, remainder, div_by_zero);
      end else begin
        got = sb.pop_front();
        if ({quotient, remainder, div_by_zero} !== {got.q, got.r, got.z}) begin
          errors++;
          $display("FAIL result got q=%0d r=%0d z=%0b expected q=%0d r=%0d z=%0b",
                   quotient, remainder, div_by_zero, got.q, got.r, got.z);
        end
      end
    end
  end
  task issue(input logic [6:0] a, input logic [3:0] b);
    exp_t e;
    dividend = a;
    divisor = b;
    start = 1'b1;
    if (b == 0) begin
      e.q = 7'h7F;
      e.r = 4'd0;
      e.z = 1'b1;
    end else begin
      e.q = a / b;
      e.r = 4'(a % b);
      e.z = 1'b0;
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
    e0 = cyc;
    b0 = busy_total;
  endtask
  task wait_done(output bit found);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      found = done;
    end
  endtask
  task test_reset;
    rst = 1'b1;
    start = 1'b0;
    dividend = 7'd0;
    divisor = 4'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done, quotient, remainder, div_by_zero} !== 14'd0) begin
      errors++;
      $display("FAIL reset_outputs got %b expected all zero", {busy, done, quotient, remainder, div_by_zero});
    end
  endtask
  task test_basic;
    issue(7'd105, 4'd7);
    wait_done(ok);
    checks++;
    if (!ok || cyc - e0 !== 7) begin
      errors++;
      $display("FAIL basic_latency got %0d expected 7 (found=%0b)", cyc - e0, ok);
    end
    checks++;
    if (busy_total - b0 !== 7) begin
      errors++;
      $display("FAIL basic_busy_cycles got %0d expected 7", busy_total - b0);
    end
    @(negedge clk);
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++;
      $display("FAIL basic_done_pulse got busy/done=%b expected 00", {busy, done});
    end
  endtask
  task test_hold;
    issue(7'd127, 4'd15);
    wait_done(ok);
    issue(7'd5, 4'd9);
    repeat (3) @(negedge clk);
    checks++;
    if ({quotient, remainder, div_by_zero} !== {7'd8, 4'd7, 1'b0}) begin
      errors++;
      $display("FAIL hold_results got q=%0d r=%0d expected q=8 r=7", quotient, remainder);
    end
    wait_done(ok);
    checks++;
    if (!ok || cyc - e0 !== 7) begin
      errors++;
      $display("FAIL back_to_back_latency got %0d expected 7 (found=%0b)", cyc - e0, ok);
    end
  endtask
  task test_div_zero;
    issue(7'd100, 4'd0);
    wait_done(ok);
    checks++;
    if (!ok || cyc - e0 !== 0 || busy_total - b0 !== 0) begin
      errors++;
      $display("FAIL div_zero_latency got %0d busy %0d expected 0 0", cyc - e0, busy_total - b0);
    end
    issue(7'd6, 4'd3);
    wait_done(ok);
    checks++;
    if (!ok || cyc - e0 !== 7) begin
      errors++;
      $display("FAIL after_zero_latency got %0d expected 7", cyc - e0);
    end
  endtask
  task test_ignore_start;
    issue(7'd42, 4'd6);
    repeat (2) @(negedge clk);
    dividend = 7'd99;
    divisor = 4'd9;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(ok);
    checks++;
    if (!ok || cyc - e0 !== 7 || busy_total - b0 !== 7) begin
      errors++;
      $display("FAIL ignore_start latency %0d busy %0d expected 7 7", cyc - e0, busy_total - b0);
    end
    repeat (10) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || sb.size() !== 0) begin
      errors++;
      $display("FAIL ignore_start_queued busy=%b pending=%0d expected 0 0", busy, sb.size());
    end
  endtask
  task test_rst_mid;
    issue(7'd120, 4'd8);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    sb.delete();
    @(negedge clk);
    checks++;
    if ({busy, done, quotient, remainder, div_by_zero} !== 14'd0) begin
      errors++;
      $display("FAIL mid_reset_outputs got %b expected all zero", {busy, done, quotient, remainder, div_by_zero});
    end
    repeat (12) @(negedge clk);
    issue(7'd120, 4'd8);
    wait_done(ok);
    checks++;
    if (!ok || cyc - e0 !== 7) begin
      errors++;
      $display("FAIL after_reset_latency got %0d expected 7", cyc - e0);
    end
  endtask
  task test_round_trip;
    for (int a = 0; a < 8; a++)
      for (int b = 1; b < 16; b++)
        for (int r = 0; r < b; r++) begin
          issue(7'(a * b + r), 4'(b));
          wait_done(ok);
          checks++;
          if (!ok) begin
            errors++;
            $display("FAIL round_trip_timeout a=%0d b=%0d r=%0d no done", a, b, r);
          end
        end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_div_zero();
    test_ignore_start();
    test_rst_mid();
    test_round_trip();
    repeat (2) @(negedge clk);
    checks++;
    if (sb.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
